// File: rtl/wb_io_pkg.sv
// Shared types and default IO address map for the Wishbone IO decoder.
package wb_io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam int          SWITCH_LED_IDX = 1;
    localparam logic [29:0] IO_MASK        = 30'h3FFF_FF00;
    localparam logic [119:0] IO_BASE_MAP   = {30'h0000_0300, 30'h0000_0200,
                                              30'h0000_0100, 30'h0000_0000};

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_addr_match.sv
// Combinational address matcher: one-hot hit with lowest-index priority, index and miss flag.
module wb_addr_match #(
    parameter int                NS         = 4,
    parameter int                IW         = 2,
    parameter logic [NS*30-1:0]  SLAVE_BASE = wb_io_pkg::IO_BASE_MAP,
    parameter logic [NS*30-1:0]  SLAVE_MASK = {NS{wb_io_pkg::IO_MASK}}
) (
    input  logic [29:0]   addr,
    output logic [NS-1:0] hit,
    output logic [IW-1:0] idx,
    output logic          miss
);

    // Scanning downwards lets the lowest matching index overwrite any higher one.
    always_comb begin
        hit  = '0;
        idx  = '0;
        miss = 1'b1;
        for (int i = NS - 1; i >= 0; i--) begin
            if ((addr & SLAVE_MASK[30*i +: 30]) == SLAVE_BASE[30*i +: 30]) begin
                hit    = '0;
                hit[i] = 1'b1;
                idx    = IW'(i);
                miss   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/wb_io_decoder.sv
// Single-master to NS-slave pipelined Wishbone decoder with response routing,
// unmapped-address error and no-ack timeout.
module wb_io_decoder
    import wb_io_pkg::*;
#(
    parameter int               NS         = 4,
    parameter logic [NS*30-1:0] SLAVE_BASE = IO_BASE_MAP,
    parameter logic [NS*30-1:0] SLAVE_MASK = {NS{IO_MASK}},
    parameter int               MAX_OUTST  = 15,
    parameter int               TIMEOUT    = 255
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic [29:0]      i_wb_addr,
    input  logic [31:0]      i_wb_data,
    input  logic [3:0]       i_wb_sel,
    output logic             o_wb_ack,
    output logic             o_wb_stall,
    output logic             o_wb_err,
    output logic [31:0]      o_wb_data,
    output logic [NS-1:0]    o_s_cyc,
    output logic [NS-1:0]    o_s_stb,
    output logic             o_s_we,
    output logic [29:0]      o_s_addr,
    output logic [31:0]      o_s_data,
    output logic [3:0]       o_s_sel,
    input  logic [NS-1:0]    i_s_ack,
    input  logic [NS-1:0]    i_s_stall,
    input  logic [NS*32-1:0] i_s_data
);

    localparam int IW = idx_width(NS);

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [3:0]      outst_q, outst_d;
    logic [7:0]      timer_q, timer_d;
    logic            err_pend_q, err_pend_d;

    logic [NS-1:0]   hit;
    logic [IW-1:0]   hit_idx;
    logic            miss;
    logic            accept;
    logic            full;

    wb_addr_match #(
        .NS         (NS),
        .IW         (IW),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_match (
        .addr (i_wb_addr),
        .hit  (hit),
        .idx  (hit_idx),
        .miss (miss)
    );

    assign o_s_we   = i_wb_we;
    assign o_s_addr = i_wb_addr;
    assign o_s_data = i_wb_data;
    assign o_s_sel  = i_wb_sel;
    assign o_wb_err = err_pend_q & i_reset_n;
    assign full     = (outst_q == 4'(MAX_OUTST));

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        o_s_cyc    = '0;
        o_s_stb    = '0;
        o_wb_stall = 1'b0;
        o_wb_ack   = 1'b0;
        o_wb_data  = '0;
        accept     = 1'b0;
        state_d    = state_q;
        owner_d    = owner_q;
        outst_d    = outst_q;
        timer_d    = timer_q;
        err_pend_d = 1'b0;

        case (state_q)
            IDLE: begin
                o_s_cyc    = {NS{i_wb_cyc & i_wb_stb}} & hit;
                o_s_stb    = {NS{i_wb_cyc & i_wb_stb}} & hit;
                o_wb_stall = miss ? 1'b0 : i_s_stall[hit_idx];
                accept     = i_wb_cyc & i_wb_stb & ~o_wb_stall;
                timer_d    = '0;
                if (accept) begin
                    if (miss) begin
                        err_pend_d = 1'b1;
                        state_d    = ERR;
                    end else begin
                        owner_d = hit_idx;
                        outst_d = 4'd1;
                        state_d = BUSY;
                    end
                end
            end

            BUSY: begin
                // A full counter holds the strobe back so the slave never sees a request the master was told to retry.
                o_s_cyc[owner_q] = i_wb_cyc;
                o_s_stb[owner_q] = i_wb_stb & hit[owner_q] & ~full;
                o_wb_stall       = (~hit[owner_q] | full) ? 1'b1 : i_s_stall[owner_q];
                accept           = i_wb_cyc & i_wb_stb & ~o_wb_stall;
                o_wb_ack         = i_wb_cyc & i_s_ack[owner_q];
                o_wb_data        = o_wb_ack ? i_s_data[32*int'(owner_q) +: 32] : 32'h0;
                outst_d          = outst_q + {3'b0, accept} - {3'b0, i_s_ack[owner_q]};

                if (o_wb_ack || accept) begin
                    timer_d = '0;
                end else if (timer_q == 8'(TIMEOUT)) begin
                    timer_d    = '0;
                    outst_d    = '0;
                    err_pend_d = 1'b1;
                    state_d    = ERR;
                end else begin
                    timer_d = timer_q + 8'd1;
                end

                if (state_d == BUSY && outst_d == 4'd0) begin
                    state_d = IDLE;
                end
            end

            ERR: begin
                o_wb_stall = 1'b1;
                timer_d    = '0;
                state_d    = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // The master dropping cyc abandons everything in flight without an error.
        if (!i_wb_cyc) begin
            state_d    = IDLE;
            outst_d    = '0;
            err_pend_d = 1'b0;
        end

        if (!i_reset_n) begin
            o_s_cyc   = '0;
            o_s_stb   = '0;
            o_wb_ack  = 1'b0;
            o_wb_data = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            outst_q    <= '0;
            timer_q    <= '0;
            err_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            outst_q    <= outst_d;
            timer_q    <= timer_d;
            err_pend_q <= err_pend_d;
        end
    end

endmodule

// File: tb/tb_wb_io_decoder.sv
// Directed bench for wb_io_decoder: per-cycle vector table plus timeout and reset sequences.
module tb_wb_io_decoder;
    import wb_io_pkg::*;

    logic         i_clk;
    logic         i_reset_n;
    logic         i_wb_cyc, i_wb_stb, i_wb_we;
    logic [29:0]  i_wb_addr;
    logic [31:0]  i_wb_data;
    logic [3:0]   i_wb_sel;
    logic         o_wb_ack, o_wb_stall, o_wb_err;
    logic [31:0]  o_wb_data;
    logic [3:0]   o_s_cyc, o_s_stb;
    logic         o_s_we;
    logic [29:0]  o_s_addr;
    logic [31:0]  o_s_data;
    logic [3:0]   o_s_sel;
    logic [3:0]   i_s_ack, i_s_stall;
    logic [127:0] i_s_data;

    int n_cmp = 0;
    int n_bad = 0;

    wb_io_decoder dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_wb_cyc   (i_wb_cyc),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .i_wb_sel   (i_wb_sel),
        .o_wb_ack   (o_wb_ack),
        .o_wb_stall (o_wb_stall),
        .o_wb_err   (o_wb_err),
        .o_wb_data  (o_wb_data),
        .o_s_cyc    (o_s_cyc),
        .o_s_stb    (o_s_stb),
        .o_s_we     (o_s_we),
        .o_s_addr   (o_s_addr),
        .o_s_data   (o_s_data),
        .o_s_sel    (o_s_sel),
        .i_s_ack    (i_s_ack),
        .i_s_stall  (i_s_stall),
        .i_s_data   (i_s_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    assign i_s_data = {32'h3333_0000, 32'h2222_0000, 32'h0000_A5A5, 32'h1111_0000};

    typedef struct {
        logic        cyc, stb, we;
        logic [29:0] addr;
        logic [3:0]  s_ack, s_stall;
        logic [3:0]  e_cyc, e_stb;
        logic        e_stall, e_ack, e_err;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic cyc, input logic stb, input logic we, input logic [29:0] addr,
                         input logic [3:0] ack, input logic [3:0] stall);
        i_wb_cyc  = cyc;
        i_wb_stb  = stb;
        i_wb_we   = we;
        i_wb_addr = addr;
        i_wb_data = {2'b10, addr};
        i_wb_sel  = 4'hF;
        i_s_ack   = ack;
        i_s_stall = stall;
    endtask

    task automatic add(input logic cyc, input logic stb, input logic we, input logic [29:0] addr,
                       input logic [3:0] ack, input logic [3:0] stall,
                       input logic [3:0] e_cyc, input logic [3:0] e_stb,
                       input logic e_stall, input logic e_ack, input logic e_err, input logic [31:0] e_data);
        vec_t v;
        v = '{cyc, stb, we, addr, ack, stall, e_cyc, e_stb, e_stall, e_ack, e_err, e_data};
        vecs.push_back(v);
    endtask

    initial begin
        int first_err;
        logic [3:0] cyc_at_err;
        logic       stall_at_err;

        i_reset_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 30'h100, 4'b0010, 4'b0000);
        #1;
        check("rst s_cyc", 32'(o_s_cyc), 32'h0);
        check("rst s_stb", 32'(o_s_stb), 32'h0);
        check("rst ack", 32'(o_wb_ack), 32'h0);
        tick();
        check("rst err", 32'(o_wb_err), 32'h0);
        i_reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 30'h0, 4'b0000, 4'b0000);
        #1;
        check("rst state", 32'(dut.state_q), 32'(IDLE));
        check("rst outst", 32'(dut.outst_q), 32'h0);
        tick();

        //    cyc  stb  we   addr      ack      stall    e_cyc    e_stb    stl  ack  err  e_data
        // single read from slave 1
        add(1, 1, 0, 30'h100, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 0, 0, 0, 32'h0);
        add(1, 0, 0, 30'h100, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 0, 1, 0, 32'h0000_A5A5);
        // pipelined writes, ack one cycle behind each request
        add(1, 1, 1, 30'h100, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 0, 0, 0, 32'h0);
        add(1, 1, 1, 30'h101, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 0, 1, 0, 32'h0000_A5A5);
        add(1, 1, 1, 30'h102, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 0, 1, 0, 32'h0000_A5A5);
        add(1, 0, 1, 30'h102, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 0, 1, 0, 32'h0000_A5A5);
        add(1, 0, 0, 30'h102, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 32'h0);
        // second slave blocked until the first owner drains
        add(1, 1, 0, 30'h100, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 0, 0, 0, 32'h0);
        add(1, 1, 0, 30'h200, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1, 0, 0, 32'h0);
        add(1, 1, 0, 30'h200, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1, 1, 0, 32'h0000_A5A5);
        add(1, 1, 0, 30'h200, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 0, 0, 0, 32'h0);
        add(1, 0, 0, 30'h200, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 0, 0, 0, 32'h0);
        add(1, 0, 0, 30'h200, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 0, 1, 0, 32'h2222_0000);
        // unmapped address
        add(1, 1, 0, 30'h800, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 32'h0);
        add(1, 0, 0, 30'h800, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 32'h0);
        add(1, 0, 0, 30'h800, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 32'h0);
        // slave stall while idle is passed through and the request is not taken
        add(1, 1, 0, 30'h300, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 1, 0, 0, 32'h0);
        add(1, 0, 0, 30'h300, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 32'h0);
        // master abort drops the transaction and a late ack is ignored
        add(1, 1, 0, 30'h000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 0, 0, 0, 32'h0);
        add(0, 0, 0, 30'h000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 32'h0);
        add(1, 0, 0, 30'h000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].addr, vecs[i].s_ack, vecs[i].s_stall);
            #1;
            check($sformatf("row%0d s_cyc", i), 32'(o_s_cyc), 32'(vecs[i].e_cyc));
            check($sformatf("row%0d s_stb", i), 32'(o_s_stb), 32'(vecs[i].e_stb));
            check($sformatf("row%0d stall", i), 32'(o_wb_stall), 32'(vecs[i].e_stall));
            check($sformatf("row%0d ack", i), 32'(o_wb_ack), 32'(vecs[i].e_ack));
            check($sformatf("row%0d err", i), 32'(o_wb_err), 32'(vecs[i].e_err));
            check($sformatf("row%0d rdata", i), o_wb_data, vecs[i].e_data);
            check($sformatf("row%0d s_addr", i), 32'(o_s_addr), 32'(vecs[i].addr));
            check($sformatf("row%0d s_we", i), 32'(o_s_we), 32'(vecs[i].we));
            check($sformatf("row%0d s_wdata", i), o_s_data, {2'b10, vecs[i].addr});
            tick();
        end
        check("s_sel", 32'(o_s_sel), 32'hF);

        // Timeout: slave 0 never acks; error appears 256 edges after the accepting edge.
        drive(1'b1, 1'b1, 1'b0, 30'h000, 4'b0000, 4'b0000);
        #1;
        check("to s_stb", 32'(o_s_stb), 32'b0001);
        tick();
        drive(1'b1, 1'b0, 1'b0, 30'h000, 4'b0000, 4'b0000);
        first_err    = 0;
        cyc_at_err   = 4'hF;
        stall_at_err = 1'b0;
        for (int k = 1; k <= 300 && first_err == 0; k++) begin
            tick();
            if (o_wb_err === 1'b1) begin
                first_err    = k;
                cyc_at_err   = o_s_cyc;
                stall_at_err = o_wb_stall;
            end
        end
        check("to err_cycle", 32'(first_err), 32'd256);
        check("to s_cyc", 32'(cyc_at_err), 32'h0);
        check("to stall", 32'(stall_at_err), 32'h1);
        tick();
        check("to err_once", 32'(o_wb_err), 32'h0);
        check("to idle", 32'(dut.state_q), 32'(IDLE));

        // Reset with three requests outstanding at slave 1, then a stale ack.
        drive(1'b1, 1'b1, 1'b1, 30'h100, 4'b0000, 4'b0000);
        tick();
        drive(1'b1, 1'b1, 1'b1, 30'h101, 4'b0000, 4'b0000);
        tick();
        drive(1'b1, 1'b1, 1'b1, 30'h102, 4'b0000, 4'b0000);
        tick();
        drive(1'b1, 1'b0, 1'b0, 30'h100, 4'b0000, 4'b0000);
        #1;
        check("rs outst3", 32'(dut.outst_q), 32'd3);
        i_reset_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 30'h100, 4'b0010, 4'b0000);
        #1;
        check("rs during s_cyc", 32'(o_s_cyc), 32'h0);
        check("rs during ack", 32'(o_wb_ack), 32'h0);
        tick();
        i_reset_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 30'h100, 4'b0010, 4'b0000);
        #1;
        check("rs stale ack", 32'(o_wb_ack), 32'h0);
        check("rs s_cyc", 32'(o_s_cyc), 32'h0);
        check("rs outst", 32'(dut.outst_q), 32'h0);
        check("rs state", 32'(dut.state_q), 32'(IDLE));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_io_decoder.md
Name: wb_io_decoder

Overview:
- Single-master to NS-slave pipelined Wishbone address decoder and response router for the IO region.
- Sits directly upstream of wb_switch_led and the other IO peripherals: the CPU data-bus port drives it, and it fans requests out to the selected slave.
- Returns acks and read data from the selected slave only.
- Adds a bus error for unmapped addresses and a no-ack timeout.

Parameters:
- NS, 4, number of slaves (1..8).
- SLAVE_BASE, {30'h0000_0300, 30'h0000_0200, 30'h0000_0100, 30'h0000_0000}, packed NS*30 word-address bases; slave i is bits [30*i+29:30*i].
- SLAVE_MASK, {NS{30'h3FFF_FF00}}, packed NS*30 compare masks.
- MAX_OUTST, 15, maximum outstanding requests; the counter is 4 bits.
- TIMEOUT, 255, cycles without an ack before an error is raised; the timer is 8 bits.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  synchronous reset, active-low.
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  master request.
- i_wb_addr  in  30  master word address.
- i_wb_data  in  32  master write data.
- i_wb_sel  in  4  master byte select.
- o_wb_ack  out  1  ack to master.
- o_wb_stall  out  1  stall to master.
- o_wb_err  out  1  bus error to master.
- o_wb_data  out  32  read data to master.
- o_s_cyc, o_s_stb  out  NS each  per-slave cycle and strobe.
- o_s_we  out  1  shared write enable.
- o_s_addr  out  30  shared address.
- o_s_data  out  32  shared write data.
- o_s_sel  out  4  shared byte select.
- i_s_ack, i_s_stall  in  NS each  per-slave ack and stall.
- i_s_data  in  NS*32  per-slave read data; slave i is bits [32*i+31:32*i].

Behaviour:
- Decode (combinational):
  - hit[i] = ((i_wb_addr & MASK_i) == BASE_i).
  - The lowest index wins on multiple hits.
  - miss = no hit.
- Registered state:
  - owner (index), outst (4 bit), timer (8 bit), err_pend (1 bit), and a state register with states IDLE, BUSY, ERR.
  - Reset (i_reset_n low at a clock edge): state=IDLE, outst=0, owner=0, timer=0, err_pend=0.
  - Outputs during and after reset: o_wb_ack=0, o_wb_err=0, o_s_cyc=0, o_s_stb=0.
- Shared slave fields pass i_wb_we/addr/data/sel through combinationally.
- IDLE:
  - o_s_cyc[i] = i_wb_cyc & i_wb_stb & hit[i]; o_s_stb identical.
  - o_wb_stall = i_s_stall[hit slave]; it is 0 on a miss.
  - Accepted hit: owner=hit index, outst=1, go to BUSY.
  - Accepted miss: err_pend=1, go to ERR.
- BUSY:
  - o_s_cyc[owner] = i_wb_cyc; all other o_s_cyc bits are 0.
  - o_s_stb[owner] = i_wb_stb & hit[owner].
  - o_wb_stall = 1 if the request targets a non-owner or misses, or if outst==MAX_OUTST; otherwise it follows i_s_stall[owner].
  - outst += accepted request; outst -= i_s_ack[owner]. A simultaneous request and ack leaves it unchanged.
  - outst reaching 0 with no new request: go to IDLE.
- Ack and data routing:
  - o_wb_ack = (state==BUSY) & i_wb_cyc & i_s_ack[owner]; acks from other slaves are ignored.
  - o_wb_data = i_s_data[owner] when o_wb_ack is 1, else 32'h0.
- ERR:
  - o_wb_err=1 for exactly one cycle (the cycle after the unmapped request); o_wb_stall=1; all o_s_cyc=0.
  - Next state is IDLE.
- Timer:
  - Clears on any o_wb_ack, on any accepted request, and in IDLE.
  - Otherwise increments in BUSY.
  - timer==TIMEOUT: go to ERR, outst=0, and owner's o_s_cyc is dropped in that ERR cycle.
- Master abort: i_wb_cyc low in any state causes next state IDLE and outst=0, with no error.
- Latency: zero added cycles on requests and responses (all combinational paths); unmapped error is returned after 1 cycle.

Decomposition:
- Package wb_io_pkg: state enum (IDLE, BUSY, ERR), default base/mask constants for the IO map, and the slave index constant (SWITCH_LED_IDX=1).
- Sub-module wb_addr_match: pure combinational hit/priority encoder producing the one-hot hit, the index and miss.

Test Plan:
1. Read to 30'h0000_0100 (slave 1); slave 1 acks the next cycle with data 32'h0000_A5A5 -> o_s_stb=4'b0010, o_wb_ack=1 one cycle later, o_wb_data=32'h0000_A5A5.
2. Pipelined writes to 30'h0100, 30'h0101, 30'h0102 on consecutive cycles with slave 1 acking one cycle after each -> no stall, outst peaks at 1, three acks, state returns to IDLE.
3. Request to slave 1, then request to slave 2 while outst=1 -> o_wb_stall=1 until slave 1 acks, then slave 2 gets o_s_stb=4'b0100.
4. Read from unmapped 30'h0000_0800 -> no o_s_stb asserted, o_wb_err=1 exactly one cycle later, o_wb_ack stays 0.
5. Request to slave 0 that never acks -> o_wb_err asserted 256 cycles after acceptance, o_s_cyc=0 that cycle, state returns to IDLE.
6. i_reset_n low for one edge while outst=3 -> outst=0, IDLE, all o_s_cyc=0; a stale ack from slave 1 the next cycle does not produce o_wb_ack.
